// File: rtl/gf163_mult_arbiter.sv
// Round-robin scheduler sharing one GF(2^163) multiplier among NUM_REQ requesters.
// Optional watchdog on the multiplier run phase: define GF_ARB_TIMEOUT_EN.
module gf163_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 163,
  parameter int TIMEOUT = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [W-1:0]         rsp_z,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 mul_rst,
  output logic                 mul_start,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic [W-1:0]         mul_z,
  input  logic                 mul_done
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("gf163_mult_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [2:0]     rr_ptr;
  logic           any_req;
  logic [2:0]     gsel;
  logic           found_hi, found_lo;
  logic [2:0]     g_hi, g_lo;
  logic [W-1:0]   sel_a, sel_b;
  logic           tmo_hit;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (3'(j) == idx) oh[j] = 1'b1;
    end
    return oh;
  endfunction

  // Rotating priority: lowest valid index at or above rr_ptr, else wrap to lowest valid index.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    g_hi     = '0;
    g_lo     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_valid[j]) begin
        if (!found_hi && (3'(j) >= rr_ptr)) begin
          found_hi = 1'b1;
          g_hi     = 3'(j);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          g_lo     = 3'(j);
        end
      end
    end
    any_req = found_lo;
    gsel    = found_hi ? g_hi : g_lo;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (3'(j) == gsel) begin
        sel_a = req_a[j*W +: W];
        sel_b = req_b[j*W +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = CLR;
      CLR:     state_nx = RUN;
      RUN:     if (mul_done || tmo_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The clear is combinational so the multiplier is held cleared for the whole of reset.
  assign mul_rst = rst | (state == CLR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_z     <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            req_ready <= onehot(gsel);
            mul_a     <= sel_a;
            mul_b     <= sel_b;
            grant_id  <= gsel;
            busy      <= 1'b1;
          end
        end
        CLR: mul_start <= 1'b1;
        RUN: begin
          if (mul_done) begin
            rsp_z     <= mul_z;
            mul_start <= 1'b0;
            rsp_valid <= onehot(grant_id);
          end else if (tmo_hit) begin
            rsp_z     <= '0;
            mul_start <= 1'b0;
            rsp_valid <= onehot(grant_id);
          end
        end
        RESP: begin
          busy   <= 1'b0;
          rr_ptr <= (grant_id == 3'(NUM_REQ-1)) ? 3'd0 : grant_id + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef GF_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (state == RUN) && !mul_done && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == CLR)      tmo_cnt <= '0;
      else if (state == RUN) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == RUN) begin
        if (mul_done)     rsp_err <= 1'b0;
        else if (tmo_hit) rsp_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_gf163_mult_arbiter.sv
// Randomised scoreboard bench for gf163_mult_arbiter with a behavioural multiplier stub.
// Timeout scenario is compiled in when GF_ARB_TIMEOUT_EN is defined.
module tb_gf163_mult_arbiter;
  localparam int N   = 4;
  localparam int W   = 163;
  localparam int TMO = 200;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_z;
  logic           rsp_err, busy;
  logic [2:0]     grant_id;
  logic           mul_rst, mul_start;
  logic [W-1:0]   mul_a, mul_b, mul_z;
  logic           mul_done;
  logic           stub_done = 1'b0;
  logic           stray_done;
  logic [W-1:0]   stub_z = '0;

  assign mul_z    = stub_z;
  assign mul_done = stub_done | stray_done;

  always #5 clk = ~clk;

  gf163_mult_arbiter #(.NUM_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id), .mul_rst(mul_rst), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .mul_done(mul_done)
  );

  typedef struct {
    int           idx;
    logic [W-1:0] z;
    bit           err;
    int           t_acc;
    int           lo;
    int           hi;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   rsp_count = 0;
  int   model_rr = 0;
  bit   stub_hold = 1'b0;
  bit   tmo_mode = 1'b0;
  exp_t exp_q[$];
  int   grant_log[$];

  logic [N-1:0]   rv_s = '0;
  logic [N*W-1:0] a_s = '0, b_s = '0;

  // Field product from the definition: carry-less multiply, then reduce by x^163+x^7+x^6+x^3+1.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-2:0] p, poly;
    p = '0;
    poly = '0;
    poly[163] = 1'b1; poly[7] = 1'b1; poly[6] = 1'b1; poly[3] = 1'b1; poly[0] = 1'b1;
    for (int i = 0; i < W; i++)
      if (b[i]) p = p ^ ({{(W-1){1'b0}}, a} << i);
    for (int i = 2*W-2; i >= W; i--)
      if (p[i]) p = p ^ (poly << (i - W));
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_fe();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rv_s <= req_valid;
    a_s  <= req_a;
    b_s  <= req_b;
  end

  // Multiplier stub: must be cleared before it will start; answers 166 cycles after start.
  int stub_cnt = 0;
  bit armed = 1'b0;
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (mul_rst) begin
      armed    <= 1'b1;
      stub_cnt <= 0;
    end else if (armed && mul_start && !stub_hold) begin
      if (stub_cnt == 165) begin
        stub_done <= 1'b1;
        stub_z    <= gf_mul(mul_a, mul_b);
        armed     <= 1'b0;
      end
      stub_cnt <= stub_cnt + 1;
    end
  end

  // Monitor: predicts grants from the sampled request vector and checks responses in order.
  always @(negedge clk) begin
    int g, lat;
    exp_t e;
    logic [N-1:0] oh;
    if (rst) begin
      exp_q.delete();
      model_rr = 0;
    end else begin
      if (req_ready != '0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && rv_s[(model_rr + k) % N]) g = (model_rr + k) % N;
        if (g < 0) begin
          chk("grant_without_request", W'(req_ready), '0);
        end else begin
          oh = '0;
          oh[g] = 1'b1;
          chk("req_ready_onehot", W'(req_ready), W'(oh));
          chk("grant_id", W'(grant_id), W'(g));
          chk("busy_on_accept", W'(busy), W'(1));
          e.idx   = g;
          e.z     = tmo_mode ? '0 : gf_mul(a_s[g*W +: W], b_s[g*W +: W]);
          e.err   = tmo_mode;
          e.t_acc = cyc;
          e.lo    = tmo_mode ? 195 : 160;
          e.hi    = tmo_mode ? 210 : 180;
          exp_q.push_back(e);
          grant_log.push_back(g);
          model_rr = (g + 1) % N;
        end
      end
      if (rsp_valid != '0) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", W'(rsp_valid), '0);
        end else begin
          e = exp_q.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          lat = cyc - e.t_acc;
          chk("rsp_valid_idx", W'(rsp_valid), W'(oh));
          chk("rsp_z", rsp_z, e.z);
          chk("rsp_err", W'(rsp_err), W'(e.err));
          chk("latency_window", W'(lat), (lat >= e.lo && lat <= e.hi) ? W'(lat) : W'(e.lo));
        end
      end
      if (exp_q.size() > 0 && (cyc - exp_q[0].t_acc) > 600) begin
        chk("rsp_never_arrived", '0, W'(exp_q[0].idx + 1));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (req_ready[i]) req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    drive_cycle();
    while (!(req_valid == '0 && !busy && exp_q.size() == 0) && n < 3000) begin
      drive_cycle();
      n++;
    end
    if (n >= 3000) chk({nm, "_idle_timeout"}, W'(n), '0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mul_rst", W'(mul_rst), W'(1));
    chk("rst_req_ready", W'(req_ready), '0);
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_rsp_z", rsp_z, '0);
    chk("rst_rsp_err", W'(rsp_err), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_grant_id", W'(grant_id), '0);
    chk("rst_mul_start", W'(mul_start), '0);
    chk("rst_mul_a", mul_a, '0);
    chk("rst_mul_b", mul_b, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [W-1:0] top, ra, rb;
    int n, target, cnt2, cnt3;
    bit reasserted;
    int fair_exp[5];
    fair_exp = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    stray_done = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Directed products through different requesters.
    issue(0, W'(1), W'(1));
    wait_idle("one");
    chk("z_1x1", rsp_z, W'(1));
    top = '0;
    top[162] = 1'b1;
    issue(1, top, W'(2));
    wait_idle("reduce");
    chk("z_reduce", rsp_z, W'(8'hC9));
    issue(3, W'(2), W'(2));
    wait_idle("two");
    chk("z_2x2", rsp_z, W'(4));

    // Stray completion pulse while idle must produce nothing.
    drive_cycle();
    stray_done = 1'b1;
    drive_cycle();
    stray_done = 1'b0;
    repeat (5) drive_cycle();
    chk("stray_busy", W'(busy), '0);

    // Fairness with all requesters valid; requester 0 reasserts after its response.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) issue(i, rand_fe(), rand_fe());
    reasserted = 1'b0;
    n = 0;
    while ((grant_log.size() < 5 || busy || req_valid != '0) && n < 4000) begin
      drive_cycle();
      if (!reasserted && rsp_valid[0]) begin
        issue(0, rand_fe(), rand_fe());
        reasserted = 1'b1;
      end
      n++;
    end
    wait_idle("fair");
    chk("fair_grant_count", W'(grant_log.size()), W'(5));
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) chk("fair_order", W'(grant_log[k]), W'(fair_exp[k]));

    // Withdrawn request while busy is never granted.
    grant_log.delete();
    issue(0, rand_fe(), rand_fe());
    repeat (3) drive_cycle();
    issue(2, rand_fe(), rand_fe());
    repeat (10) drive_cycle();
    req_valid[2] = 1'b0;
    issue(3, rand_fe(), rand_fe());
    wait_idle("withdraw");
    cnt2 = 0;
    cnt3 = 0;
    foreach (grant_log[k]) begin
      if (grant_log[k] == 2) cnt2++;
      if (grant_log[k] == 3) cnt3++;
    end
    chk("withdrawn_not_granted", W'(cnt2), '0);
    chk("follower_granted", W'(cnt3), W'(1));

    // Asynchronous reset in the middle of a multiplication.
    issue(1, rand_fe(), rand_fe());
    n = 0;
    while (!mul_start && n < 20) begin
      drive_cycle();
      n++;
    end
    chk("mul_start_rises", W'(mul_start), W'(1));
    repeat (50) drive_cycle();
    rst = 1'b1;
    #1;
    chk("midrst_mul_rst", W'(mul_rst), W'(1));
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_mul_start", W'(mul_start), '0);
    chk("midrst_rsp_valid", W'(rsp_valid), '0);
    drive_cycle();
    chk("midrst_mul_rst_held", W'(mul_rst), W'(1));
    drive_cycle();
    rst = 1'b0;
    #1;
    chk("after_rst_mul_rst_low", W'(mul_rst), '0);
    repeat (250) drive_cycle();
    chk("after_rst_idle", W'(busy), '0);
    ra = rand_fe();
    rb = rand_fe();
    issue(2, ra, rb);
    wait_idle("post_rst");
    chk("post_rst_product", rsp_z, gf_mul(ra, rb));

    // Random traffic with random withdrawals.
    target = rsp_count + 12;
    n = 0;
    while (rsp_count < target && n < 6000) begin
      drive_cycle();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 29) == 0) issue(i, rand_fe(), rand_fe());
        else if (req_valid[i] && $urandom_range(0, 299) == 0) req_valid[i] = 1'b0;
      end
      n++;
    end
    chk("random_progress", W'(rsp_count >= target), W'(1));
    wait_idle("random");

`ifdef GF_ARB_TIMEOUT_EN
    // Multiplier never completes: watchdog answers with zero and an error flag.
    stub_hold = 1'b1;
    tmo_mode = 1'b1;
    issue(0, rand_fe(), rand_fe());
    wait_idle("timeout");
    stub_hold = 1'b0;
    tmo_mode = 1'b0;
    ra = rand_fe();
    rb = rand_fe();
    issue(1, ra, rb);
    wait_idle("after_timeout");
    chk("after_timeout_product", rsp_z, gf_mul(ra, rb));
    chk("after_timeout_err_clear", W'(rsp_err), '0);
`endif

    repeat (3) drive_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
